pkt_stim_gen: RTL and testbench
===============================

# pkt_stim_gen

Parametrised NetFPGA-style packet stimulus generator. It is the next-generation replacement for the fixed test data source that drives a `convertable_fifo_controller` input (`in_data`/`in_ctrl`/`in_wr`/`in_rdy`) in CPU/FIFO bring-up benches and on-chip self-test. Software or a bench configures packet length, packet count, inter-packet gap and payload mode, then pulses `start`. The block emits framed packets under `out_rdy` flow control and reports progress and completion.

## Interface
Parameters:
- `DATA_WIDTH`, 64, data bus width; multiple of 32, at least 64.
- `CTRL_WIDTH`, `DATA_WIDTH/8`, ctrl bus width.
- `LEN_W`, 8, width of `pkt_words`.
- `CNT_W`, 8, width of `num_pkts` and `pkts_sent`.
- `HDR_CTRL`, all ones, ctrl value on the header word.
- `EOP_CTRL`, 8'h80 zero-extended, ctrl value on the last word.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse that launches a run; ignored while `busy`.
- `pkt_words`  in  `LEN_W`  words per packet, header included; sampled at `start`.
- `num_pkts`  in  `CNT_W`  packets per run; sampled at `start`.
- `gap`  in  8  idle cycles between packets; sampled at `start`.
- `mode`  in  1  payload mode: 0 = incrementing, 1 = LFSR; sampled at `start`.
- `out_data`  out  `DATA_WIDTH`  packet word.
- `out_ctrl`  out  `CTRL_WIDTH`  word ctrl.
- `out_wr`  out  1  word valid.
- `out_rdy`  in  1  downstream can accept a word.
- `busy`  out  1  run in progress.
- `done`  out  1  one-cycle pulse when a run completes.
- `pkts_sent`  out  `CNT_W`  packets completed in the current or last run.

## Operation
- States: IDLE, HDR, PAY, GAP.
  - IDLE: on `start`, capture the config, clear `pkts_sent`, and reseed the LFSR to 32'hACE10001. Go to HDR, or stay in IDLE and pulse `done` if `num_pkts`=0.
  - HDR: emit the header word. Go to PAY.
  - PAY: emit words 1 through L-1, where L is the effective packet length. After the last word, increment `pkts_sent`. If `pkts_sent+1`=`num_pkts`, pulse `done` and go to IDLE. Otherwise go to GAP, or directly to HDR if `gap`=0.
  - GAP: count `gap` cycles with `out_wr`=0, then go to HDR.
- Effective length L = max(`pkt_words`, 2).
- Header word:
  - `out_ctrl`=`HDR_CTRL`.
  - `out_data` = {packet index [15:0], L zero-extended to 16 bits, 32'hC0DEFEED}, placed in the low 64 bits; upper bits are 0.
- Payload words:
  - `out_ctrl`=0, except the last word, which carries `EOP_CTRL`.
  - Mode 0: each 32-bit lane = {packet index [15:0], word index [15:0]}.
  - Mode 1: each 32-bit lane = the current LFSR value. The LFSR is a Galois register with polynomial 0x80200003 and steps once per emitted payload word.
- All arithmetic is unsigned and wraps modulo the field width.
- `start` while `busy` is ignored, and the configuration is not re-sampled.

## Timing
- Reset values (next edge with `rst`=1): `out_data`=0, `out_ctrl`=0, `out_wr`=0, `busy`=0, `done`=0, `pkts_sent`=0, state=IDLE, LFSR=32'hACE10001.
- `rst` mid-packet truncates the packet. No EOP is emitted.
- All outputs are registered.
- Flow control:
  - In HDR or PAY, if `out_rdy`=1 at an edge, the next word is registered with `out_wr`=1 and the word pointer advances.
  - If `out_rdy`=0, `out_wr`=0 and the pointer and LFSR hold.
  - Downstream must tolerate one word after it drops `out_rdy`.
- Latency: the first header appears with `out_wr`=1 two edges after the `start` edge, when `out_rdy` is held high.
- `busy` rises the edge after `start` and falls in the same cycle that `done` pulses.
- `done` pulses the cycle after the final EOP word is registered.
- `pkts_sent` updates in the same cycle that EOP is registered.

## Configuration
- `PKTGEN_LFSR_EN` defined: the LFSR and mode 1 are available as described.
- `PKTGEN_LFSR_EN` undefined: no LFSR logic is built, `mode` is ignored, and the payload is always mode 0.

## Test plan
- `pkt_words`=4, `num_pkts`=2, `gap`=0, `mode`=0, `out_rdy`=1:
  - Produces 8 consecutive `out_wr` cycles, with ctrl sequence FF,00,00,80,FF,00,00,80.
  - Word 2 of packet 1 = 0x0001000200010002.
  - `done` pulses once; `pkts_sent`=2.
- `pkt_words`=1, `num_pkts`=1: the packet is exactly 2 words (FF, 80), and the header length field = 2.
- `num_pkts`=0: no `out_wr`; `done` pulses one cycle after `start`; `busy` stays 0.
- `gap`=3, `num_pkts`=2, `pkt_words`=3: exactly 3 idle cycles between the EOP of packet 0 and the header of packet 1.
- `out_rdy` toggling with a 50% random pattern, `mode`=1 (`PKTGEN_LFSR_EN` defined):
  - The word stream is identical to the `out_rdy`=1 run.
  - First payload lane = 32'hACE10001, and the next lane is one LFSR step later.
- `rst` asserted mid-PAY:
  - All outputs are 0 the next cycle.
  - `start` after reset re-runs cleanly, and a `start` issued while `busy` has no effect.

Source files
------------

// File: rtl/pkt_stim_gen_if.sv
// Packet output bus of pkt_stim_gen: word, ctrl, write strobe and ready.
// The master drives the word stream and the slave returns out_rdy.
interface pkt_stim_gen_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned CTRL_WIDTH = DATA_WIDTH / 8
);
  logic [DATA_WIDTH-1:0] out_data;
  logic [CTRL_WIDTH-1:0] out_ctrl;
  logic                  out_wr;
  logic                  out_rdy;

  modport master (output out_data, output out_ctrl, output out_wr, input out_rdy);
  modport slave  (input out_data, input out_ctrl, input out_wr, output out_rdy);
endinterface

// File: rtl/pkt_stim_gen.sv
// Packet stimulus generator. It emits framed packets (a header word followed
// by payload words, with EOP ctrl on the last word) under out_rdy flow control.
// Build option PKTGEN_LFSR_EN adds the LFSR payload mode (mode=1). Without it,
// mode is ignored and the payload is always the incrementing pattern.
module pkt_stim_gen #(
  parameter int unsigned           DATA_WIDTH = 64,
  parameter int unsigned           CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned           LEN_W      = 8,
  parameter int unsigned           CNT_W      = 8,
  parameter logic [CTRL_WIDTH-1:0] HDR_CTRL   = '1,
  parameter logic [CTRL_WIDTH-1:0] EOP_CTRL   = CTRL_WIDTH'(8'h80)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_W-1:0]      pkt_words,
  input  logic [CNT_W-1:0]      num_pkts,
  input  logic [7:0]            gap,
  input  logic                  mode,
  pkt_stim_gen_if.master        out_bus,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      pkts_sent
);

  localparam int unsigned LANES = DATA_WIDTH / 32;

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAY, S_GAP} state_t;

  state_t                r_state, w_state_nxt;
  logic [LEN_W-1:0]      r_len, w_len_nxt;
  logic [LEN_W-1:0]      r_ptr, w_ptr_nxt;
  logic [CNT_W-1:0]      r_num, w_num_nxt;
  logic [CNT_W-1:0]      r_sent, w_sent_nxt, w_sent_inc;
  logic [7:0]            r_gap, w_gap_nxt;
  logic [7:0]            r_gcnt, w_gcnt_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  r_done, w_done_nxt;
  logic                  r_wr, w_wr_nxt;
  logic [DATA_WIDTH-1:0] r_data, w_data_nxt;
  logic [CTRL_WIDTH-1:0] r_ctrl, w_ctrl_nxt;
  logic [DATA_WIDTH-1:0] w_hdr, w_pay;
  logic                  w_last;

`ifdef PKTGEN_LFSR_EN
  localparam logic [31:0] LFSR_SEED = 32'hACE10001;
  logic [31:0] r_lfsr, w_lfsr_nxt;
  logic        r_mode, w_mode_nxt;

  function automatic logic [31:0] f_lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h80200003) : (s >> 1);
  endfunction
`else
  logic w_unused_mode;
  assign w_unused_mode = mode;
`endif

  // Word images for the current pointer and packet index.
  always_comb begin
    w_hdr        = '0;
    w_hdr[63:0]  = {16'(r_sent), 16'(r_len), 32'hC0DEFEED};
    w_pay        = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      w_pay[i*32 +: 32] = {16'(r_sent), 16'(r_ptr)};
`ifdef PKTGEN_LFSR_EN
      if (r_mode) w_pay[i*32 +: 32] = r_lfsr;
`endif
    end
  end

  // Next-state and next-output logic. A completed run parks in IDLE with busy
  // still high for one cycle; that cycle raises done and drops busy together.
  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_len;
    w_ptr_nxt   = r_ptr;
    w_num_nxt   = r_num;
    w_sent_nxt  = r_sent;
    w_gap_nxt   = r_gap;
    w_gcnt_nxt  = r_gcnt;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_wr_nxt    = 1'b0;
    w_data_nxt  = r_data;
    w_ctrl_nxt  = r_ctrl;
`ifdef PKTGEN_LFSR_EN
    w_lfsr_nxt  = r_lfsr;
    w_mode_nxt  = r_mode;
`endif
    w_last      = (r_ptr == r_len - LEN_W'(1));
    w_sent_inc  = r_sent + CNT_W'(1);
    case (r_state)
      S_IDLE: begin
        if (r_busy) begin
          w_busy_nxt = 1'b0;
          w_done_nxt = 1'b1;
        end else if (start) begin
          w_len_nxt  = (pkt_words < LEN_W'(2)) ? LEN_W'(2) : pkt_words;
          w_num_nxt  = num_pkts;
          w_gap_nxt  = gap;
          w_sent_nxt = '0;
`ifdef PKTGEN_LFSR_EN
          w_lfsr_nxt = LFSR_SEED;
          w_mode_nxt = mode;
`endif
          if (num_pkts == '0) begin
            w_done_nxt = 1'b1;
          end else begin
            w_busy_nxt  = 1'b1;
            w_state_nxt = S_HDR;
          end
        end
      end
      S_HDR: begin
        if (out_bus.out_rdy) begin
          w_wr_nxt    = 1'b1;
          w_data_nxt  = w_hdr;
          w_ctrl_nxt  = HDR_CTRL;
          w_ptr_nxt   = LEN_W'(1);
          w_state_nxt = S_PAY;
        end
      end
      S_PAY: begin
        if (out_bus.out_rdy) begin
          w_wr_nxt   = 1'b1;
          w_data_nxt = w_pay;
          w_ctrl_nxt = w_last ? EOP_CTRL : '0;
          w_ptr_nxt  = r_ptr + LEN_W'(1);
`ifdef PKTGEN_LFSR_EN
          w_lfsr_nxt = f_lfsr_step(r_lfsr);
`endif
          if (w_last) begin
            w_sent_nxt = w_sent_inc;
            if (w_sent_inc == r_num) begin
              w_state_nxt = S_IDLE;
            end else if (r_gap == 8'd0) begin
              w_state_nxt = S_HDR;
            end else begin
              w_gcnt_nxt  = '0;
              w_state_nxt = S_GAP;
            end
          end
        end
      end
      S_GAP: begin
        w_gcnt_nxt = r_gcnt + 8'd1;
        if (r_gcnt == r_gap - 8'd1) w_state_nxt = S_HDR;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and registered outputs; reset truncates any packet in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_len   <= '0;
      r_ptr   <= '0;
      r_num   <= '0;
      r_sent  <= '0;
      r_gap   <= '0;
      r_gcnt  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_wr    <= 1'b0;
      r_data  <= '0;
      r_ctrl  <= '0;
`ifdef PKTGEN_LFSR_EN
      r_lfsr  <= LFSR_SEED;
      r_mode  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_len   <= w_len_nxt;
      r_ptr   <= w_ptr_nxt;
      r_num   <= w_num_nxt;
      r_sent  <= w_sent_nxt;
      r_gap   <= w_gap_nxt;
      r_gcnt  <= w_gcnt_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_wr    <= w_wr_nxt;
      r_data  <= w_data_nxt;
      r_ctrl  <= w_ctrl_nxt;
`ifdef PKTGEN_LFSR_EN
      r_lfsr  <= w_lfsr_nxt;
      r_mode  <= w_mode_nxt;
`endif
    end
  end

  assign out_bus.out_data = r_data;
  assign out_bus.out_ctrl = r_ctrl;
  assign out_bus.out_wr   = r_wr;
  assign busy             = r_busy;
  assign done             = r_done;
  assign pkts_sent        = r_sent;

endmodule

// File: tb/tb_pkt_stim_gen.sv
// Bench for pkt_stim_gen: a packet-stream model fills an expected-word queue,
// a monitor compares every written word against it, and directed tests pin
// framing, timing, gaps, flow control, reset and start-while-busy behaviour.
module tb_pkt_stim_gen;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  c;
    int          cyc;
  } wrd_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] pkt_words = '0;
  logic [7:0] num_pkts = '0;
  logic [7:0] gap = '0;
  logic       mode = 1'b0;
  logic       busy, done;
  logic [7:0] pkts_sent;
  logic       rdy_v = 1'b1;
  logic       rdy_edge = 1'b1;
  logic       rnd_rdy = 1'b0;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  logic busy_seen = 1'b0;
  wrd_t exp_q[$];
  wrd_t cap[$];

  pkt_stim_gen_if #(.DATA_WIDTH(64), .CTRL_WIDTH(8)) bus ();
  assign bus.out_rdy = rdy_v;

  pkt_stim_gen #(.DATA_WIDTH(64), .CTRL_WIDTH(8), .LEN_W(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .pkt_words(pkt_words),
    .num_pkts(num_pkts), .gap(gap), .mode(mode), .out_bus(bus),
    .busy(busy), .done(done), .pkts_sent(pkts_sent)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    rdy_edge = rdy_v;
    if (rnd_rdy) begin
      #2;
      rdy_v = 1'($urandom_range(0, 1));
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h80200003) : (s >> 1);
  endfunction

  // Expected stream: for each packet a header, then L-1 payload words.
  task automatic build(input int len, input int num, input bit md);
    int          l;
    bit          m;
    logic [31:0] lf;
    logic [31:0] lane;
    logic [15:0] p16;
    l  = (len < 2) ? 2 : len;
    lf = 32'hACE10001;
`ifdef PKTGEN_LFSR_EN
    m = md;
`else
    m = 1'b0;
    if (md) m = 1'b0;
`endif
    for (int p = 0; p < num; p++) begin
      p16 = 16'(p % 256);
      exp_q.push_back('{d: {p16, 16'(l), 32'hC0DEFEED}, c: 8'hFF, cyc: 0});
      for (int w = 1; w < l; w++) begin
        if (m) begin
          lane = lf;
          lf   = lfsr_step(lf);
        end else begin
          lane = {p16, 16'(w)};
        end
        exp_q.push_back('{d: {lane, lane}, c: (w == l - 1) ? 8'h80 : 8'h00, cyc: 0});
      end
    end
  endtask

  // Monitor: compares every written word against the model queue.
  always @(negedge clk) begin
    wrd_t e;
    if (!rst) begin
      if (busy) busy_seen = 1'b1;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("busy_low_at_done", {63'd0, busy}, 64'd0);
      end
      if (bus.out_wr) begin
        chk("wr_needs_rdy", {63'd0, rdy_edge}, 64'd1);
        cap.push_back('{d: bus.out_data, c: bus.out_ctrl, cyc: cyc});
        chk("word_expected", {63'd0, exp_q.size() != 0}, 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("word_data", bus.out_data, e.d);
          chk("word_ctrl", {56'd0, bus.out_ctrl}, {56'd0, e.c});
        end
      end
    end
  end

  task automatic clr();
    done_cnt  = 0;
    busy_seen = 1'b0;
    cap.delete();
  endtask

  task automatic run(input int len, input int num, input int g, input bit md, output int scyc);
    build(len, num, md);
    @(negedge clk);
    pkt_words = 8'(len);
    num_pkts  = 8'(num);
    gap       = 8'(g);
    mode      = md;
    start     = 1'b1;
    scyc      = cyc;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", {63'd0, busy}, {63'd0, num != 0});
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_within_budget", {63'd0, done_cnt != 0}, 64'd1);
    repeat (6) @(negedge clk);
  endtask

  initial begin
    int          s;
    int          n;
    logic [7:0]  t1_ctrl [8];
    logic [63:0] lit;
    t1_ctrl = '{8'hFF, 8'h00, 8'h00, 8'h80, 8'hFF, 8'h00, 8'h00, 8'h80};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_wr",   {63'd0, bus.out_wr}, 64'd0);
    chk("rst_data", bus.out_data, 64'd0);
    chk("rst_ctrl", {56'd0, bus.out_ctrl}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_sent", {56'd0, pkts_sent}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Two 4-word packets back to back
    clr();
    run(4, 2, 0, 1'b0, s);
    wait_done(200);
    chk("t1_words", 64'(cap.size()), 64'd8);
    if (cap.size() == 8) begin
      chk("t1_first_hdr_cycle", 64'(cap[0].cyc), 64'(s + 2));
      chk("t1_consecutive", 64'(cap[7].cyc - cap[0].cyc), 64'd7);
      for (int i = 0; i < 8; i++) chk("t1_ctrl_seq", {56'd0, cap[i].c}, {56'd0, t1_ctrl[i]});
      lit = 64'h0001000200010002;
      chk("t1_p1_word2", cap[6].d, lit);
      chk("t1_done_cycle", 64'(done_cyc), 64'(cap[7].cyc + 1));
    end
    chk("t1_done_once", 64'(done_cnt), 64'd1);
    chk("t1_pkts_sent", {56'd0, pkts_sent}, 64'd2);
    chk("t1_busy_end", {63'd0, busy}, 64'd0);
    chk("t1_stream_complete", 64'(exp_q.size()), 64'd0);

    // Length 1 is stretched to 2
    clr();
    run(1, 1, 0, 1'b0, s);
    wait_done(100);
    chk("t2_words", 64'(cap.size()), 64'd2);
    if (cap.size() == 2) begin
      chk("t2_ctrl0", {56'd0, cap[0].c}, 64'hFF);
      chk("t2_ctrl1", {56'd0, cap[1].c}, 64'h80);
      chk("t2_hdr_len", {48'd0, cap[0].d[47:32]}, 64'd2);
    end
    chk("t2_stream_complete", 64'(exp_q.size()), 64'd0);

    // Zero packets: done only
    clr();
    run(4, 0, 0, 1'b0, s);
    wait_done(20);
    chk("t3_no_words", 64'(cap.size()), 64'd0);
    chk("t3_done_cycle", 64'(done_cyc), 64'(s + 1));
    chk("t3_done_once", 64'(done_cnt), 64'd1);
    chk("t3_never_busy", {63'd0, busy_seen}, 64'd0);

    // Inter-packet gap of 3
    clr();
    run(3, 2, 3, 1'b0, s);
    wait_done(100);
    chk("t4_words", 64'(cap.size()), 64'd6);
    if (cap.size() == 6) begin
      chk("t4_gap_cycles", 64'(cap[3].cyc - cap[2].cyc - 1), 64'd3);
      chk("t4_pkt1_hdr", cap[3].d, 64'h00010003C0DEFEED);
    end
    chk("t4_stream_complete", 64'(exp_q.size()), 64'd0);

    // LFSR payload with random out_rdy
    clr();
    rnd_rdy = 1'b1;
    run(5, 3, 1, 1'b1, s);
    wait_done(600);
    @(negedge clk);
    rnd_rdy = 1'b0;
    rdy_v   = 1'b1;
    chk("t5_words", 64'(cap.size()), 64'd15);
    if (cap.size() >= 3) begin
`ifdef PKTGEN_LFSR_EN
      lit = 64'hACE10001ACE10001;
      chk("t5_first_lane", cap[1].d, lit);
      lit = 64'hD6508003D6508003;
      chk("t5_second_lane", cap[2].d, lit);
`else
      lit = 64'h0000000100000001;
      chk("t5_first_lane", cap[1].d, lit);
`endif
    end
    chk("t5_pkts_sent", {56'd0, pkts_sent}, 64'd3);
    chk("t5_stream_complete", 64'(exp_q.size()), 64'd0);

    // Reset mid-payload, then clean rerun with an ignored start
    clr();
    run(8, 2, 0, 1'b0, s);
    n = 0;
    while (cap.size() < 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t6_reached_payload", {63'd0, cap.size() >= 3}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_wr",   {63'd0, bus.out_wr}, 64'd0);
    chk("t6_rst_data", bus.out_data, 64'd0);
    chk("t6_rst_ctrl", {56'd0, bus.out_ctrl}, 64'd0);
    chk("t6_rst_busy", {63'd0, busy}, 64'd0);
    chk("t6_rst_done", {63'd0, done}, 64'd0);
    chk("t6_rst_sent", {56'd0, pkts_sent}, 64'd0);
    exp_q.delete();
    rst = 1'b0;
    @(negedge clk);
    clr();
    run(3, 1, 0, 1'b0, s);
    pkt_words = 8'd6;
    num_pkts  = 8'd4;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(100);
    chk("t6_words", 64'(cap.size()), 64'd3);
    if (cap.size() == 3) chk("t6_hdr_len", {48'd0, cap[0].d[47:32]}, 64'd3);
    chk("t6_done_once", 64'(done_cnt), 64'd1);
    chk("t6_pkts_sent", {56'd0, pkts_sent}, 64'd1);
    chk("t6_stream_complete", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
